lock_round_ctrl: RTL and testbench
==================================

Name: lock_round_ctrl

Overview:
- Round controller for the joystick combination-lock checker.
- Generates a fresh 4-digit code from a free-running LFSR and drives it onto the checker's num_1..num_4 inputs.
- Holds the checker in reset between rounds and times each round.
- Counts wrong key presses and timeouts; enforces a lockout after MAX_FAILS failures; reports unlock/lock status to the display/LED logic.

Parameters:
- TIMEOUT_CYCLES, 500_000_000, cycles allowed per digit (10 s at 50 MHz); reloaded on every checker advance.
- LOCKOUT_CYCLES, 1_500_000_000, lockout duration in cycles.
- HOLD_CYCLES, 100_000_000, duration of the unlocked indication in cycles.
- MAX_FAILS, 3, failures that trigger lockout; legal range 1..3.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a round
- key_valid  in  1  single-cycle pulse; key_press holds a new key
- key_press  in  4  keypad code; bits [2:0] are compared
- joy_state  in  3  checker state: 0..3 = digit index, 4 = pass
- pass_flag  in  1  checker pass indication
- num_1..num_4  out  3 each  code digits to the checker
- checker_rst_n  out  1  active-low reset to the checker
- ctrl_state  out  3  current controller state, for debug/display
- fail_count  out  2  failures in the current sequence
- unlocked  out  1  high during SUCCESS
- locked_out  out  1  high during LOCKOUT

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low.
- Reset values: state IDLE; num_1..num_4 = 3'd1; checker_rst_n 0; fail_count 0; unlocked 0; locked_out 0; timer 0; lfsr = LFSR_SEED.
- All outputs are registered.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle in every state, never stalls, and is never zero.
- FSM states: IDLE=0, GEN=1, ARMED=2, SUCCESS=3, FAIL=4, LOCKOUT=5.
- IDLE: checker_rst_n=0. start -> GEN.
- GEN: lasts exactly 1 cycle.
  - Latch num_1=lfsr[2:0], num_2=lfsr[5:3], num_3=lfsr[8:6], num_4=lfsr[11:9].
  - Any field equal to 0 is replaced by 1 (key code 0 means "no key").
  - Load timer = TIMEOUT_CYCLES-1. Go to ARMED.
- ARMED: checker_rst_n=1 from the first ARMED cycle. Timer decrements each cycle. Evaluate in this priority order:
  1. pass_flag -> SUCCESS.
  2. key_valid with joy_state<=3 and key_press[2:0] != expected digit (num_{joy_state+1}) -> FAIL.
  3. Timer==0 -> FAIL.
  4. joy_state differs from its registered previous value -> reload timer = TIMEOUT_CYCLES-1.
- Simultaneous events in ARMED: pass_flag wins over a wrong key and over timeout. A wrong key and timeout in the same cycle count as one failure.
- start while not in IDLE is ignored.
- key_valid outside ARMED is ignored and is not counted.
- SUCCESS:
  - Entry: unlocked=1, checker_rst_n=0, fail_count cleared, timer = HOLD_CYCLES-1.
  - Timer==0 -> IDLE with unlocked=0.
- FAIL: lasts exactly 1 cycle, checker_rst_n=0, fail_count += 1.
  - If the new count == MAX_FAILS: timer = LOCKOUT_CYCLES-1, go to LOCKOUT.
  - Else go to GEN (new code, new round, no start needed).
- LOCKOUT: locked_out=1, checker_rst_n=0, start ignored. Timer==0 -> IDLE, fail_count cleared, locked_out=0.
- Latency: start sampled in IDLE -> GEN on the next edge -> ARMED one edge later; digits are valid before checker_rst_n deasserts.
- Timer width: $clog2 of the largest of TIMEOUT/LOCKOUT/HOLD. The timer never wraps; it is only loaded on state entry or checker advance.
- fail_count saturates at MAX_FAILS.
- Reset mid-round: immediate return to reset values; the checker is forced into reset the same instant.

Decomposition:
- Package lock_pkg: enum ctrl_state_t (6 states, 3 bits), localparam CHK_PASS=3'd4, digit_t (logic [2:0]).
- One sub-module, lfsr16: clk, reset_n, seed parameter, 16-bit out.
- Timer and FSM stay in lock_round_ctrl.

Test Plan:
Bench parameters: TIMEOUT_CYCLES=20, LOCKOUT_CYCLES=10, HOLD_CYCLES=5, MAX_FAILS=3, LFSR_SEED=16'hACE1.
1. Reset then start pulse -> ctrl_state 0->1->2 on consecutive edges; num_* nonzero and equal to the LFSR fields latched in GEN (zero fields forced to 1); checker_rst_n rises the same edge ctrl_state=2.
2. Model the checker stepping joy_state 0..4, then pass_flag=1 -> SUCCESS next edge; unlocked high exactly 5 cycles; return to IDLE; fail_count=0.
3. In ARMED, joy_state=1, key_valid with key_press=num_2^3'b001 -> FAIL for one cycle, fail_count=1, GEN, ARMED with a new code.
4. No activity for 20 cycles in ARMED -> FAIL; repeat three times -> LOCKOUT, locked_out high 10 cycles, start pulses during lockout ignored, then IDLE with fail_count=0.
5. pass_flag, timer==0 and a wrong key_valid in the same cycle -> SUCCESS, fail_count unchanged.
6. Assert reset_n low mid-ARMED with joy_state=2 -> checker_rst_n=0 and all outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/lock_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the combination-lock round controller.
package lock_pkg;

  typedef logic [2:0] digit_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GEN     = 3'd1,
    ST_ARMED   = 3'd2,
    ST_SUCCESS = 3'd3,
    ST_FAIL    = 3'd4,
    ST_LOCKOUT = 3'd5
  } ctrl_state_t;

  // Checker joy_state value meaning "all digits entered".
  localparam digit_t CHK_PASS = 3'd4;

  // Key code 0 means "no key", so a generated digit may never be 0.
  function automatic digit_t nz_digit(digit_t d);
    return (d == 3'd0) ? 3'd1 : d;
  endfunction

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lfsr16.sv
`timescale 1ns/1ps
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11); advances every cycle, never stalls.
// A nonzero seed keeps the register out of the all-zero lock-up state.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] lfsr
);

  logic feedback;

  assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[14:0], feedback};
    end
  end

endmodule

// File: rtl/lock_round_ctrl.sv
`timescale 1ns/1ps
// Round controller for the combination-lock checker: code generation, per-digit timeout, failure count, lockout.
// start -> GEN next edge -> ARMED one edge later; all outputs registered, no backpressure (pulse inputs only).
module lock_round_ctrl
  import lock_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 500_000_000,
  parameter int          LOCKOUT_CYCLES = 1_500_000_000,
  parameter int          HOLD_CYCLES    = 100_000_000,
  parameter int          MAX_FAILS      = 3,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       key_valid,
  input  logic [3:0] key_press,
  input  logic [2:0] joy_state,
  input  logic       pass_flag,
  output logic [2:0] num_1,
  output logic [2:0] num_2,
  output logic [2:0] num_3,
  output logic [2:0] num_4,
  output logic       checker_rst_n,
  output logic [2:0] ctrl_state,
  output logic [1:0] fail_count,
  output logic       unlocked,
  output logic       locked_out
);

  localparam int TMAX = max3(TIMEOUT_CYCLES, LOCKOUT_CYCLES, HOLD_CYCLES);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] T_TIMEOUT = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCKOUT = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_HOLD    = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [1:0]    FAIL_LIM  = 2'(MAX_FAILS);

  ctrl_state_t      state, state_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic [1:0]       fail_nxt;
  digit_t [3:0]     code_q, code_nxt;
  logic [2:0]       joy_prev;
  logic [15:0]      lfsr;
  logic             wrong_key;
  logic             joy_moved;
  logic             unused_bits;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .lfsr    (lfsr)
  );

  // Only key_press[2:0] carries a digit; upper LFSR bits are not part of the code.
  assign unused_bits = ^{key_press[3], lfsr[15:12]};

  assign wrong_key = key_valid && (joy_state < CHK_PASS) &&
                     (key_press[2:0] != code_q[joy_state[1:0]]);
  assign joy_moved = (joy_state != joy_prev);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    fail_nxt  = fail_count;
    code_nxt  = code_q;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_GEN;
      end
      ST_GEN: begin
        for (int i = 0; i < 4; i++) begin
          code_nxt[i] = nz_digit(lfsr[3*i +: 3]);
        end
        timer_nxt = T_TIMEOUT;
        state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        // A wrong key and a timeout in the same cycle are one failure; pass beats both.
        if (pass_flag) begin
          state_nxt = ST_SUCCESS;
          timer_nxt = T_HOLD;
          fail_nxt  = 2'd0;
        end else if (wrong_key || (timer == '0)) begin
          state_nxt = ST_FAIL;
          fail_nxt  = (fail_count < FAIL_LIM) ? fail_count + 2'd1 : fail_count;
        end else if (joy_moved) begin
          timer_nxt = T_TIMEOUT;
        end else begin
          timer_nxt = timer - T_ONE;
        end
      end
      ST_SUCCESS: begin
        if (timer == '0) state_nxt = ST_IDLE;
        else             timer_nxt = timer - T_ONE;
      end
      ST_FAIL: begin
        if (fail_count == FAIL_LIM) begin
          state_nxt = ST_LOCKOUT;
          timer_nxt = T_LOCKOUT;
        end else begin
          state_nxt = ST_GEN;
        end
      end
      ST_LOCKOUT: begin
        if (timer == '0) begin
          state_nxt = ST_IDLE;
          fail_nxt  = 2'd0;
        end else begin
          timer_nxt = timer - T_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Status outputs follow the next state so they change on the same edge as ctrl_state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer         <= '0;
      fail_count    <= 2'd0;
      code_q        <= {4{3'd1}};
      joy_prev      <= 3'd0;
      checker_rst_n <= 1'b0;
      unlocked      <= 1'b0;
      locked_out    <= 1'b0;
    end else begin
      timer         <= timer_nxt;
      fail_count    <= fail_nxt;
      code_q        <= code_nxt;
      joy_prev      <= joy_state;
      checker_rst_n <= (state_nxt == ST_ARMED);
      unlocked      <= (state_nxt == ST_SUCCESS);
      locked_out    <= (state_nxt == ST_LOCKOUT);
    end
  end

  assign num_1      = code_q[0];
  assign num_2      = code_q[1];
  assign num_3      = code_q[2];
  assign num_4      = code_q[3];
  assign ctrl_state = state;

endmodule

// File: tb/tb_lock_round_ctrl.sv
`timescale 1ns/1ps
// Bench for lock_round_ctrl: directed round sequences, a vector table, and random traffic
// checked every cycle against a deadline-based reference model.
module tb_lock_round_ctrl;

  localparam int          TIMEOUT = 20;
  localparam int          LOCKOUT = 10;
  localparam int          HOLD    = 5;
  localparam int          MAXF    = 3;
  localparam logic [15:0] SEED    = 16'hACE1;

  localparam int S_IDLE = 0, S_GEN = 1, S_ARMED = 2, S_SUCCESS = 3, S_FAIL = 4, S_LOCKOUT = 5;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       key_valid;
  logic [3:0] key_press;
  logic [2:0] joy_state;
  logic       pass_flag;
  logic [2:0] num_1, num_2, num_3, num_4;
  logic       checker_rst_n;
  logic [2:0] ctrl_state;
  logic [1:0] fail_count;
  logic       unlocked;
  logic       locked_out;

  always #5 clk = ~clk;

  lock_round_ctrl #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .LOCKOUT_CYCLES (LOCKOUT),
    .HOLD_CYCLES    (HOLD),
    .MAX_FAILS      (MAXF),
    .LFSR_SEED      (SEED)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .key_valid     (key_valid),
    .key_press     (key_press),
    .joy_state     (joy_state),
    .pass_flag     (pass_flag),
    .num_1         (num_1),
    .num_2         (num_2),
    .num_3         (num_3),
    .num_4         (num_4),
    .checker_rst_n (checker_rst_n),
    .ctrl_state    (ctrl_state),
    .fail_count    (fail_count),
    .unlocked      (unlocked),
    .locked_out    (locked_out)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: tracks absolute edge count and the deadline of the running interval.
  int          cyc, m_st, m_mark, m_dur, m_fails;
  logic [2:0]  m_prevjoy;
  logic [15:0] m_lfsr;
  logic [2:0]  m_code [4];

  typedef struct {
    logic [2:0] joy;
    logic       kv;
    logic [2:0] x;
    logic       b3;
    logic       pass;
    int         exp_state;
    int         exp_fail;
    int         exp_unl;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [15:0] lfsr_next(logic [15:0] s);
    return {s[14:0], ^(s & 16'hB400)};
  endfunction

  function automatic logic [2:0] code_digit(logic [15:0] s, int i);
    logic [2:0] d;
    d = 3'((s >> (3 * i)) & 16'h0007);
    return (d == 3'd0) ? 3'd1 : d;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; m_st = S_IDLE; m_mark = 0; m_dur = 0; m_fails = 0;
    m_prevjoy = 3'd0; m_lfsr = SEED;
    for (int i = 0; i < 4; i++) m_code[i] = 3'd1;
  endtask

  task automatic model_edge();
    bit expired, wrong;
    cyc++;
    expired = (cyc - m_mark) >= m_dur;
    wrong   = key_valid && (joy_state <= 3'd3) && (key_press[2:0] != m_code[joy_state[1:0]]);
    case (m_st)
      S_IDLE:    if (start) m_st = S_GEN;
      S_GEN: begin
        for (int i = 0; i < 4; i++) m_code[i] = code_digit(m_lfsr, i);
        m_st = S_ARMED; m_mark = cyc; m_dur = TIMEOUT;
      end
      S_ARMED: begin
        if (pass_flag) begin
          m_st = S_SUCCESS; m_mark = cyc; m_dur = HOLD; m_fails = 0;
        end else if (wrong || expired) begin
          m_st = S_FAIL;
          if (m_fails < MAXF) m_fails++;
        end else if (joy_state != m_prevjoy) begin
          m_mark = cyc;
        end
      end
      S_SUCCESS: if (expired) m_st = S_IDLE;
      S_FAIL: begin
        if (m_fails == MAXF) begin
          m_st = S_LOCKOUT; m_mark = cyc; m_dur = LOCKOUT;
        end else begin
          m_st = S_GEN;
        end
      end
      S_LOCKOUT: if (expired) begin m_st = S_IDLE; m_fails = 0; end
      default: m_st = S_IDLE;
    endcase
    m_prevjoy = joy_state;
    m_lfsr    = lfsr_next(m_lfsr);
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_state"},  int'(ctrl_state),    m_st);
    chk({tag, "_num1"},   int'(num_1),         int'(m_code[0]));
    chk({tag, "_num2"},   int'(num_2),         int'(m_code[1]));
    chk({tag, "_num3"},   int'(num_3),         int'(m_code[2]));
    chk({tag, "_num4"},   int'(num_4),         int'(m_code[3]));
    chk({tag, "_crst"},   int'(checker_rst_n), int'(m_st == S_ARMED));
    chk({tag, "_fails"},  int'(fail_count),    m_fails);
    chk({tag, "_unlock"}, int'(unlocked),      int'(m_st == S_SUCCESS));
    chk({tag, "_lock"},   int'(locked_out),    int'(m_st == S_LOCKOUT));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"},  int'(ctrl_state),    S_IDLE);
    chk({tag, "_num1"},   int'(num_1),         1);
    chk({tag, "_num2"},   int'(num_2),         1);
    chk({tag, "_num3"},   int'(num_3),         1);
    chk({tag, "_num4"},   int'(num_4),         1);
    chk({tag, "_crst"},   int'(checker_rst_n), 0);
    chk({tag, "_fails"},  int'(fail_count),    0);
    chk({tag, "_unlock"}, int'(unlocked),      0);
    chk({tag, "_lock"},   int'(locked_out),    0);
  endtask

  // Called 1 time unit after an edge: reset lands mid-cycle, outputs are checked before any edge.
  task automatic async_reset(input string tag);
    #2;
    reset_n = 1'b0;
    start = 1'b0; key_valid = 1'b0; pass_flag = 1'b0; joy_state = 3'd0; key_press = 4'd0;
    model_reset();
    #1;
    check_reset_values(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drive_random();
    int r;
    r = $urandom_range(0, 99);
    start     = ($urandom_range(0, 9) == 0);
    key_valid = 1'b0;
    pass_flag = 1'b0;
    key_press = 4'($urandom_range(0, 15));
    if (m_st == S_ARMED) begin
      if (joy_state < 3'd4 && r < 8) begin
        joy_state = 3'(joy_state + 3'd1);
      end else if (r < 40 && joy_state < 3'd4) begin
        key_valid = 1'b1;
        key_press = {1'($urandom_range(0, 1)), m_code[joy_state[1:0]]};
      end else if (r < 43 && joy_state < 3'd4) begin
        key_valid = 1'b1;
        key_press = {1'b0, m_code[joy_state[1:0]] ^ 3'($urandom_range(1, 7))};
      end
      if (joy_state == 3'd4 && r >= 90) pass_flag = 1'b1;
    end else begin
      joy_state = 3'd0;
      key_valid = (r < 20);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the test completed");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] gen_lfsr;

    //                joy   kv    x     b3    pass  state      fail unl
    vecs[0] = '{3'd0, 1'b1, 3'd0, 1'b1, 1'b0, S_ARMED,   0, 0};
    vecs[1] = '{3'd0, 1'b1, 3'd1, 1'b0, 1'b0, S_FAIL,    1, 0};
    vecs[2] = '{3'd3, 1'b1, 3'd0, 1'b0, 1'b0, S_ARMED,   0, 0};
    vecs[3] = '{3'd3, 1'b1, 3'd4, 1'b0, 1'b0, S_FAIL,    1, 0};
    vecs[4] = '{3'd4, 1'b1, 3'd7, 1'b0, 1'b0, S_ARMED,   0, 0};
    vecs[5] = '{3'd1, 1'b0, 3'd5, 1'b0, 1'b0, S_ARMED,   0, 0};
    vecs[6] = '{3'd2, 1'b1, 3'd2, 1'b0, 1'b1, S_SUCCESS, 0, 1};
    vecs[7] = '{3'd2, 1'b1, 3'd0, 1'b1, 1'b0, S_ARMED,   0, 0};
    vecs[8] = '{3'd0, 1'b0, 3'd0, 1'b0, 1'b1, S_SUCCESS, 0, 1};

    reset_n = 1'b1; start = 1'b0; key_valid = 1'b0; key_press = 4'd0;
    joy_state = 3'd0; pass_flag = 1'b0;
    #1 reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;

    // Start latency and code latch.
    start = 1'b1; cycle("s1"); start = 1'b0;
    chk("s1_gen_state", int'(ctrl_state), S_GEN);
    chk("s1_gen_crst", int'(checker_rst_n), 0);
    gen_lfsr = m_lfsr;
    cycle("s1");
    chk("s1_armed_state", int'(ctrl_state), S_ARMED);
    chk("s1_armed_crst", int'(checker_rst_n), 1);
    chk("s1_num1", int'(num_1), int'(code_digit(gen_lfsr, 0)));
    chk("s1_num2", int'(num_2), int'(code_digit(gen_lfsr, 1)));
    chk("s1_num3", int'(num_3), int'(code_digit(gen_lfsr, 2)));
    chk("s1_num4", int'(num_4), int'(code_digit(gen_lfsr, 3)));
    chk("s1_nonzero", int'(num_1 != 0 && num_2 != 0 && num_3 != 0 && num_4 != 0), 1);

    // Full correct entry, then pass.
    for (int j = 0; j < 4; j++) begin
      key_valid = 1'b1; key_press = {1'b0, m_code[j]}; cycle("s2");
      key_valid = 1'b0; joy_state = 3'(j + 1); cycle("s2");
      chk("s2_still_armed", int'(ctrl_state), S_ARMED);
    end
    pass_flag = 1'b1; cycle("s2"); pass_flag = 1'b0; joy_state = 3'd0;
    chk("s2_success", int'(ctrl_state), S_SUCCESS);
    n = 0;
    while (unlocked && n < 20) begin n++; cycle("s2"); end
    chk("s2_unlock_cycles", n, HOLD);
    chk("s2_idle", int'(ctrl_state), S_IDLE);
    chk("s2_fails", int'(fail_count), 0);

    // Wrong key on the second digit.
    start = 1'b1; cycle("s3"); start = 1'b0; cycle("s3");
    joy_state = 3'd1; cycle("s3");
    key_valid = 1'b1; key_press = {1'b0, m_code[1] ^ 3'b001}; cycle("s3");
    key_valid = 1'b0; joy_state = 3'd0;
    chk("s3_fail_state", int'(ctrl_state), S_FAIL);
    chk("s3_fail_count", int'(fail_count), 1);
    chk("s3_fail_crst", int'(checker_rst_n), 0);
    cycle("s3");
    chk("s3_regen", int'(ctrl_state), S_GEN);
    cycle("s3");
    chk("s3_rearmed", int'(ctrl_state), S_ARMED);
    chk("s3_count_kept", int'(fail_count), 1);

    // Two timeouts take the count to the limit and into lockout.
    for (int rep = 0; rep < 2; rep++) begin
      n = 0;
      while (ctrl_state == 3'(S_ARMED) && n < 40) begin cycle("s4"); n++; end
      chk("s4_timeout_cycles", n, TIMEOUT);
      chk("s4_fail_state", int'(ctrl_state), S_FAIL);
      chk("s4_fail_count", int'(fail_count), rep + 2);
      cycle("s4");
      if (rep == 0) cycle("s4");
    end
    chk("s4_lockout", int'(ctrl_state), S_LOCKOUT);
    n = 0;
    while (locked_out && n < 30) begin start = n[0]; n++; cycle("s4"); end
    start = 1'b0;
    chk("s4_lock_cycles", n, LOCKOUT);
    chk("s4_idle", int'(ctrl_state), S_IDLE);
    chk("s4_fails_cleared", int'(fail_count), 0);
    cycle("s4");
    chk("s4_stays_idle", int'(ctrl_state), S_IDLE);

    // Pass, timeout and wrong key in the same cycle.
    start = 1'b1; cycle("s5"); start = 1'b0; cycle("s5");
    repeat (TIMEOUT - 1) cycle("s5");
    chk("s5_armed", int'(ctrl_state), S_ARMED);
    pass_flag = 1'b1; key_valid = 1'b1; key_press = {1'b0, m_code[0] ^ 3'b010};
    cycle("s5");
    pass_flag = 1'b0; key_valid = 1'b0;
    chk("s5_success", int'(ctrl_state), S_SUCCESS);
    chk("s5_fails", int'(fail_count), 0);
    chk("s5_unlocked", int'(unlocked), 1);
    n = 0;
    while (ctrl_state != 3'(S_IDLE) && n < 20) begin cycle("s5"); n++; end
    chk("s5_back_idle", int'(ctrl_state), S_IDLE);

    // Asynchronous reset mid-round.
    start = 1'b1; cycle("s6"); start = 1'b0; cycle("s6");
    joy_state = 3'd1; cycle("s6");
    joy_state = 3'd2; cycle("s6");
    chk("s6_armed", int'(ctrl_state), S_ARMED);
    async_reset("s6_rst");

    // Single-cycle event table applied on a freshly armed round.
    for (int k = 0; k < 9; k++) begin
      async_reset("tbl_rst");
      start = 1'b1; cycle("tbl"); start = 1'b0; cycle("tbl");
      joy_state = vecs[k].joy;
      key_valid = vecs[k].kv;
      key_press = {vecs[k].b3, m_code[vecs[k].joy[1:0]] ^ vecs[k].x};
      pass_flag = vecs[k].pass;
      cycle("tbl");
      key_valid = 1'b0; pass_flag = 1'b0; joy_state = 3'd0;
      chk($sformatf("tbl%0d_state", k),  int'(ctrl_state), vecs[k].exp_state);
      chk($sformatf("tbl%0d_fails", k),  int'(fail_count), vecs[k].exp_fail);
      chk($sformatf("tbl%0d_unlock", k), int'(unlocked),   vecs[k].exp_unl);
    end

    // Randomized traffic against the model.
    async_reset("rnd_rst");
    for (int i = 0; i < 4000; i++) begin
      drive_random();
      cycle("rnd");
      if (i % 1000 == 999) async_reset("rnd_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
